dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_bytearray.sv | 32 +++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// legal byte-enable patterns, statistics width and small helpers.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] WE_LOAD = 4'b0000;
   localparam logic [3:0] WE_B0   = 4'b0001;
   localparam logic [3:0] WE_B1   = 4'b0010;
   localparam logic [3:0] WE_B2   = 4'b0100;
   localparam logic [3:0] WE_B3   = 4'b1000;
   localparam logic [3:0] WE_H0   = 4'b0011;
   localparam logic [3:0] WE_H1   = 4'b1100;
   localparam logic [3:0] WE_W    = 4'b1111;

   localparam int STAT_W = 16;

   // True when the enable pattern is legal and its lanes match the byte offset.
   function automatic logic lane_ok(input logic [3:0] we, input logic [1:0] a);
      logic ok;
      case (we)
         WE_LOAD: ok = 1'b1;
         WE_B0:   ok = (a == 2'd0);
         WE_B1:   ok = (a == 2'd1);
         WE_B2:   ok = (a == 2'd2);
         WE_B3:   ok = (a == 2'd3);
         WE_H0:   ok = (a == 2'd0);
         WE_H1:   ok = (a == 2'd2);
         WE_W:    ok = (a == 2'd0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_bytearray.sv
// DEPTH_WORDS x 32 storage with per-byte-lane write enables and a registered
// read port; write and read happen together on an enabled edge.
module dmem_bytearray #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           en,
   input  logic [3:0]                     we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   // Read returns the pre-write contents of the word.
   always_comb rdata_d = mem[idx];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels, LATENCY
// wait states, misalignment/range checking. DMEM_STATS_EN adds 16-bit
// saturating load/store/error counters.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_we,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [15:0] err_count
`endif
);

   localparam int AW     = $clog2(DEPTH_WORDS);
   localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  we_q, we_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rd_gate_q, rd_gate_d;

   logic [31:0] cur_addr, cur_wdata;
   logic [3:0]  cur_we;
   logic        cur_err, enter_resp;
   logic [31:0] ram_rdata;

   // In IDLE the live request is used so LATENCY=0 can commit on the accepting edge.
   always_comb begin
      cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
      cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
      cur_we    = (state_q == IDLE) ? req_we    : we_q;
      cur_err   = (cur_addr[31:2] >= 30'(DEPTH_WORDS)) | ~lane_ok(cur_we, cur_addr[1:0]);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rd_gate_d   = rd_gate_q;
      enter_resp  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               we_d        = req_we;
               req_ready_d = 1'b0;
               if (LATENCY > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(LAT_M1);
               end else begin
                  enter_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) enter_resp = 1'b1;
            else               cnt_d      = cnt_q - 4'd1;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rd_gate_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         state_d     = RESP;
         rsp_valid_d = 1'b1;
         rsp_err_d   = cur_err;
         rd_gate_d   = ~cur_err & (cur_we == WE_LOAD);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_gate_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_gate_q   <= rd_gate_d;
      end
   end

   dmem_bytearray #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .en    (enter_resp),
      .we    (cur_err ? 4'b0000 : cur_we),
      .idx   (cur_addr[AW+1:2]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rd_gate_q ? ram_rdata : 32'h0;

`ifdef DMEM_STATS_EN
   logic [STAT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
   logic              hs;

   // rd_gate_q marks a good load, so a good store is the remaining non-error case.
   always_comb begin
      hs        = (state_q == RESP) & rsp_ready;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_cnt_d = err_cnt_q;
      if (hs) begin
         if (rsp_err_q)      err_cnt_d = sat_inc(err_cnt_q);
         else if (rd_gate_q) rd_cnt_d  = sat_inc(rd_cnt_q);
         else                wr_cnt_d  = sat_inc(wr_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;
   assign err_count = err_cnt_q;
`else
   // Statistics disabled: no counter state or ports.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases plus randomized traffic
// against a word-array reference model; monitor checks latency and stability.
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_we = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_STATS_EN
   logic [15:0] rd_count, wr_count, err_count;
`endif

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_we    (req_we),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
      ,
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        is_ld;
      int          acc;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   exp_t        q[$];
   logic [31:0] mdl [int];
   bit          hold = 1'b0;
   int          n_rd = 0, n_wr = 0, n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rules: range, then lane legality by number of enabled bytes.
   function automatic bit mdl_err(input logic [31:0] a, input logic [3:0] we);
      logic [3:0] one = 4'b0001;
      logic [3:0] two = 4'b0011;
      if (a[31:2] >= 30'(DEPTH)) return 1'b1;
      case ($countones(we))
         0: return 1'b0;
         1: return we != (one << a[1:0]);
         2: return a[0] || (we != (two << a[1:0]));
         4: return a[1:0] != 2'd0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                         input bit commit);
      exp_t        e;
      bit          ok = 1'b0;
      int          idx = int'(a[31:2]);
      logic [31:0] w;
      @(negedge clk);
      req_addr = a; req_wdata = d; req_we = we; req_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      e.err   = mdl_err(a, we);
      e.is_ld = (we == 4'b0000);
      e.acc   = cyc;
      e.rdata = 32'h0;
      if (!e.err) begin
         w = mdl.exists(idx) ? mdl[idx] : 32'h0;
         if (e.is_ld) e.rdata = w;
         else if (commit) begin
            for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = d[8*i +: 8];
            mdl[idx] = w;
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         if (q.size() == 0) return;
         @(negedge clk);
      end
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1 rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: latency on rising rsp_valid, stability while stalled, pop on handshake.
   logic        pv = 1'b0, pr = 1'b0, pe = 1'b0;
   logic [31:0] pd = '0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("hold_valid", 32'(rsp_valid), 32'd1);
               chk("hold_rdata", rsp_rdata, pd);
               chk("hold_err", 32'(rsp_err), 32'(pe));
            end
            if (rsp_valid) chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (rsp_valid && !pv) begin
               if (q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding");
               end else chk("latency", 32'(cyc), 32'(q[0].acc + LAT + 1));
            end
            if (rsp_valid && rsp_ready && q.size() > 0) begin
               e = q.pop_front();
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_rdata", rsp_rdata, e.rdata);
               if (e.err) n_err++;
               else if (e.is_ld) n_rd++;
               else n_wr++;
            end
            pv = rsp_valid; pr = rsp_ready; pd = rsp_rdata; pe = rsp_err;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] we_tab [14] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                  4'hC, 4'hF, 4'h6, 4'h7, 4'h5, 4'h9, 4'hE};
      int         wsel [11] = '{0, 1, 2, 3, 4, 5, 6, 7, DEPTH-1, DEPTH, DEPTH+3};
      logic [31:0] a;

      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
`ifdef DMEM_STATS_EN
      chk("rst_rd_count", 32'(rd_count), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;

      do_req(32'h10, 32'hDEADBEEF, 4'hF, 1'b1); wait_idle();
      do_req(32'h10, 32'h0, 4'h0, 1'b1);        wait_idle();
      do_req(32'h10, 32'h11223344, 4'hF, 1'b1); wait_idle();
      do_req(32'h12, 32'h5A5A5A5A, 4'h4, 1'b1); wait_idle();
      do_req(32'h10, 32'h0, 4'h0, 1'b1);        wait_idle();
      do_req(32'h13, 32'hFFFFFFFF, 4'h3, 1'b1); wait_idle();
      do_req(32'h10, 32'h0, 4'h0, 1'b1);        wait_idle();
      do_req(32'(DEPTH*4), 32'h0, 4'h0, 1'b1);  wait_idle();
      do_req(32'(DEPTH*4-4), 32'h0BADF00D, 4'hF, 1'b1); wait_idle();
      do_req(32'(DEPTH*4-4), 32'h0, 4'h0, 1'b1); wait_idle();

      // Stall the response for five cycles.
      hold = 1'b1;
      @(posedge clk);
      do_req(32'h10, 32'h0, 4'h0, 1'b1);
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_rdata", rsp_rdata, 32'h115A3344);
         @(negedge clk);
      end
      hold = 1'b0;
      wait_idle();

      // Reset while a store sits in WAIT: the write never commits.
      do_req(32'h10, 32'hCAFEF00D, 4'hF, 1'b0);
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_rsp_err", 32'(rsp_err), 32'd0);
      chk("abort_rsp_rdata", rsp_rdata, 32'h0);
      q.delete();
      n_rd = 0; n_wr = 0; n_err = 0;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
`ifdef DMEM_STATS_EN
      chk("abort_rd_count", 32'(rd_count), 32'd0);
      chk("abort_wr_count", 32'(wr_count), 32'd0);
      chk("abort_err_count", 32'(err_count), 32'd0);
`endif
      do_req(32'h10, 32'h0, 4'h0, 1'b1); wait_idle();

      for (int w = 0; w < 8; w++) begin
         do_req(32'(w * 4), $urandom, 4'hF, 1'b1);
      end
      do_req(32'(DEPTH*4-4), $urandom, 4'hF, 1'b1);
      wait_idle();

      for (int n = 0; n < 300; n++) begin
         a = {wsel[$urandom_range(0, 10)][29:0], 2'(($urandom_range(0, 3)))};
         do_req(a, $urandom, we_tab[$urandom_range(0, 13)], 1'b1);
      end
      wait_idle();

`ifdef DMEM_STATS_EN
      @(negedge clk);
      chk("rd_count", 32'(rd_count), 32'(n_rd));
      chk("wr_count", 32'(wr_count), 32'(n_wr));
      chk("err_count", 32'(err_count), 32'(n_err));
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
